pwm_3lmod: RTL

Carrier-based three-level modulator that generates the 2-bit voltage-level command (v_lev) consumed by the 3L NPC/NPP/ANPC commutation decoder.
- Compares a signed, shadow-buffered modulation reference against a symmetric up/down triangular carrier.
- Enforces a minimum zero-level dwell on every P<->N sign change.
- Emits a carrier-valley sync pulse for ADC/control-loop alignment.

---
 rtl/pwm_3lmod_pkg.sv | 25 ++
 rtl/pwm_3lmod_carrier_updown.sv | 50 +++++
 rtl/pwm_3lmod.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pwm_3lmod_pkg.sv
// rtl/pwm_3lmod_pkg.sv - shared level and state types for the three-level modulator
package pwm_3lmod_pkg;

  typedef enum logic [1:0] {
    V_N = 2'b00,
    V_O = 2'b01,
    V_P = 2'b10
  } vlev_t;

  typedef enum logic [1:0] {
    LEV_N,
    LEV_O,
    LEV_P,
    DWELL
  } modstate_t;

  function automatic modstate_t level_state(input vlev_t lev);
    case (lev)
      V_P:     return LEV_P;
      V_N:     return LEV_N;
      default: return LEV_O;
    endcase
  endfunction

endpackage

// File: rtl/pwm_3lmod_carrier_updown.sv
// rtl/pwm_3lmod_carrier_updown.sv - symmetric up/down carrier with valley sync and update strobe
module pwm_3lmod_carrier_updown #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 upd_peak,
  input  logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 dir,
  output logic                 sync,
  output logic                 run,
  output logic                 upd
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  assign run  = en && (period != '0);
  assign sync = run && (cnt == '0);
  assign upd  = (cnt == '0) || (upd_peak && dir && (cnt == period));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      dir <= 1'b1;
    end else if (!run) begin
      cnt <= '0;
      dir <= 1'b1;
    end else if (dir) begin
      if (cnt >= period) begin
        // a period of 1 turns straight back into the valley
        cnt <= cnt - ONE;
        dir <= (cnt == ONE);
      end else begin
        cnt <= cnt + ONE;
      end
    end else begin
      if (cnt <= ONE) begin
        cnt <= '0;
        dir <= 1'b1;
      end else if (cnt > period) begin
        cnt <= period;
      end else begin
        cnt <= cnt - ONE;
      end
    end
  end

endmodule

// File: rtl/pwm_3lmod.sv
// rtl/pwm_3lmod.sv - carrier-based three-level modulator with zero-dwell on sign change
module pwm_3lmod
  import pwm_3lmod_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int TD_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH:0]   mref,
  input  logic                 mref_wr,
  input  logic                 upd_peak,
  input  logic [TD_WIDTH-1:0]  t_zmin,
  output logic [1:0]           v_lev,
  output logic [CNT_WIDTH-1:0] cnt_out,
  output logic                 dir,
  output logic                 sync,
  output logic                 dwell
);

  localparam logic [TD_WIDTH-1:0] TD_ONE = TD_WIDTH'(1);

  logic [CNT_WIDTH-1:0] sh_period, act_period;
  logic [CNT_WIDTH:0]   sh_mref, act_mref;
  logic                 run, upd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_period  <= '0;
      sh_mref    <= '0;
      act_period <= '0;
      act_mref   <= '0;
    end else begin
      if (mref_wr) begin
        sh_period <= period;
        sh_mref   <= mref;
      end
      // a write landing on the update cycle bypasses the shadow
      if (upd) begin
        act_period <= mref_wr ? period : sh_period;
        act_mref   <= mref_wr ? mref : sh_mref;
      end
    end
  end

  pwm_3lmod_carrier_updown #(.CNT_WIDTH(CNT_WIDTH)) u_carrier (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .upd_peak (upd_peak),
    .period   (act_period),
    .cnt      (cnt_out),
    .dir      (dir),
    .sync     (sync),
    .run      (run),
    .upd      (upd)
  );

  logic [CNT_WIDTH:0]   mref_abs;
  logic [CNT_WIDTH-1:0] mag;
  vlev_t                des;

  // unsigned view of the negation keeps the most-negative reference exact
  assign mref_abs = act_mref[CNT_WIDTH] ? -act_mref : act_mref;
  assign mag      = (mref_abs > {1'b0, act_period}) ? act_period : mref_abs[CNT_WIDTH-1:0];

  always_comb begin
    des = V_O;
    if (run && (mag > cnt_out)) des = act_mref[CNT_WIDTH] ? V_N : V_P;
  end

  modstate_t             state, state_nxt;
  logic [TD_WIDTH-1:0]   timer, timer_nxt, dwell_load;

  assign dwell_load = (t_zmin == '0) ? TD_ONE : t_zmin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LEV_O;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    if (!run) begin
      state_nxt = LEV_O;
      timer_nxt = '0;
    end else begin
      case (state)
        LEV_O: state_nxt = level_state(des);
        LEV_P: begin
          if (des == V_O) state_nxt = LEV_O;
          else if (des == V_N) begin
            state_nxt = DWELL;
            timer_nxt = dwell_load;
          end
        end
        LEV_N: begin
          if (des == V_O) state_nxt = LEV_O;
          else if (des == V_P) begin
            state_nxt = DWELL;
            timer_nxt = dwell_load;
          end
        end
        DWELL: begin
          if (timer <= TD_ONE) begin
            state_nxt = level_state(des);
            timer_nxt = '0;
          end else begin
            timer_nxt = timer - TD_ONE;
          end
        end
        default: state_nxt = LEV_O;
      endcase
    end
  end

  assign v_lev = (state == LEV_P) ? V_P : (state == LEV_N) ? V_N : V_O;
  assign dwell = (state == DWELL);

endmodule
